// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the instruction sequencer and the PC unit.
package pc_sequencer_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int unsigned CNT_W_DEFAULT   = 8;
  localparam int unsigned BR_W            = 3;

  // Branch-type encoding understood by the PC unit
  localparam logic [BR_W-1:0] JMP_NONE   = 3'd0;
  localparam logic [BR_W-1:0] JMP_JAL    = 3'd1;
  localparam logic [BR_W-1:0] JMP_JALR   = 3'd2;
  localparam logic [BR_W-1:0] JMP_BRANCH = 3'd3;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_DECODE,
    ST_MEM,
    ST_WB,
    ST_HALT,
    ST_TRAP
  } seq_state_t;

endpackage

// File: rtl/pc_sequencer_mem_wait_timer.sv
// Wait-cycle counter shared by the fetch and data-memory waits.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic count,
  output logic expired_c
);

  logic [CNT_W-1:0] cnt;

  // Asserted in the last allowed wait cycle: one more low-ready cycle reaches TIMEOUT
  assign expired_c = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && !expired_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle control FSM sequencing PC unit, instruction and data memory,
// one instruction at a time, with halt/trap status and a retired counter.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W   = CNT_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            imem_ready,
  input  logic            dmem_ready,
  input  logic            dec_load,
  input  logic            dec_store,
  input  logic            dec_rd_we,
  input  logic            dec_halt,
  input  logic            dec_illegal,
  input  logic [BR_W-1:0] dec_branch_type,
  output logic            imem_req,
  output logic            ir_we,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic            reg_we,
  output logic            stay,
  output logic [BR_W-1:0] branch_type,
  output logic            halted,
  output logic            trap,
  output logic [31:0]     retired
);

  seq_state_t state, state_next;
  logic       waiting_c;
  logic       ready_c;
  logic       expired_c;

  assign waiting_c = (state == ST_FETCH) || (state == ST_MEM);
  assign ready_c   = (state == ST_FETCH) ? imem_ready : dmem_ready;

  // Counter sits at zero outside the wait states, so it is clear on every entry
  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (!waiting_c),
    .count     (waiting_c && !ready_c),
    .expired_c (expired_c)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT:   state_next = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready)     state_next = ST_DECODE;
        else if (expired_c) state_next = ST_TRAP;
      end
      ST_DECODE: begin
        if (dec_illegal)                 state_next = ST_TRAP;
        else if (dec_halt)               state_next = ST_HALT;
        else if (dec_load || dec_store)  state_next = ST_MEM;
        else                             state_next = ST_WB;
      end
      ST_MEM: begin
        if (dmem_ready)     state_next = ST_WB;
        else if (expired_c) state_next = ST_TRAP;
      end
      ST_WB:     state_next = ST_FETCH;
      ST_HALT:   state_next = ST_HALT;
      ST_TRAP:   state_next = ST_TRAP;
      default:   state_next = ST_BOOT;
    endcase
  end

  // Control outputs decode from the registered state; only ir_we sees a ready
  always_comb begin
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    reg_we      = 1'b0;
    stay        = 1'b1;
    branch_type = JMP_NONE;
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_store;
      end
      ST_WB: begin
        stay        = 1'b0;
        reg_we      = dec_rd_we;
        branch_type = dec_branch_type;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      retired <= '0;
      halted  <= 1'b0;
      trap    <= 1'b0;
    end else begin
      if (state == ST_WB) retired <= retired + 32'd1;
      if (state_next == ST_HALT) halted <= 1'b1;
      if (state_next == ST_TRAP) trap <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: cycle vector table plus corner sequences.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  localparam logic [31:0] JAL_OFF = 32'h40;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic imem_ready, dmem_ready, dec_load, dec_store, dec_rd_we, dec_halt, dec_illegal;
  logic [2:0] dec_branch_type;

  logic imem_req, ir_we, dmem_req, dmem_we, reg_we, stay, halted, trap;
  logic [2:0] branch_type;
  logic [31:0] retired;

  logic t4_imem_req, t4_ir_we, t4_dmem_req, t4_dmem_we, t4_reg_we, t4_stay, t4_halted, t4_trap;
  logic [2:0] t4_branch_type;
  logic [31:0] t4_retired;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.TIMEOUT(8), .CNT_W(8)) u_dut (
    .clk(clk), .rstn(rstn), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .dec_load(dec_load), .dec_store(dec_store), .dec_rd_we(dec_rd_we),
    .dec_halt(dec_halt), .dec_illegal(dec_illegal), .dec_branch_type(dec_branch_type),
    .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .reg_we(reg_we), .stay(stay), .branch_type(branch_type), .halted(halted),
    .trap(trap), .retired(retired)
  );

  pc_sequencer #(.TIMEOUT(4), .CNT_W(8)) u_t4 (
    .clk(clk), .rstn(rstn), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .dec_load(dec_load), .dec_store(dec_store), .dec_rd_we(dec_rd_we),
    .dec_halt(dec_halt), .dec_illegal(dec_illegal), .dec_branch_type(dec_branch_type),
    .imem_req(t4_imem_req), .ir_we(t4_ir_we), .dmem_req(t4_dmem_req), .dmem_we(t4_dmem_we),
    .reg_we(t4_reg_we), .stay(t4_stay), .branch_type(t4_branch_type), .halted(t4_halted),
    .trap(t4_trap), .retired(t4_retired)
  );

  // Minimal PC unit: advances when not held, JAL jumps by a fixed offset
  logic [31:0] pc;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) pc <= '0;
    else if (!stay) pc <= (branch_type == JMP_JAL) ? pc + JAL_OFF : pc + 32'd4;
  end

  // in  = {imem_ready, dmem_ready, ld, st, rd_we, halt, illegal, bt[2:0]}
  // out = {imem_req, ir_we, dmem_req, dmem_we, reg_we, stay, bt[2:0], halted, trap}
  typedef struct {
    logic [9:0]  in;
    logic [10:0] out;
    logic [31:0] ret;
    logic [31:0] pc;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    {imem_ready, dmem_ready, dec_load, dec_store, dec_rd_we, dec_halt, dec_illegal} = '0;
    dec_branch_type = JMP_NONE;
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [9:0] in, input logic [10:0] out, input int ret, input int pcv);
    vec_t v;
    v.in = in; v.out = out; v.ret = 32'(ret); v.pc = 32'(pcv);
    vecs.push_back(v);
  endtask

  initial begin
    vec_t e;
    // ALU x2
    add(10'b10_001_00_000, 11'b00_00_01_000_00, 0, 0);
    add(10'b10_001_00_000, 11'b11_00_01_000_00, 0, 0);
    add(10'b10_001_00_000, 11'b00_00_01_000_00, 0, 0);
    add(10'b10_001_00_000, 11'b00_00_10_000_00, 0, 0);
    add(10'b10_001_00_000, 11'b11_00_01_000_00, 1, 4);
    add(10'b10_001_00_000, 11'b00_00_01_000_00, 1, 4);
    add(10'b10_001_00_000, 11'b00_00_10_000_00, 1, 4);
    // Load, dmem_ready after 5 wait cycles
    add(10'b10_101_00_000, 11'b11_00_01_000_00, 2, 8);
    add(10'b10_101_00_000, 11'b00_00_01_000_00, 2, 8);
    for (int k = 0; k < 5; k++) add(10'b10_101_00_000, 11'b00_10_01_000_00, 2, 8);
    add(10'b11_101_00_000, 11'b00_10_01_000_00, 2, 8);
    add(10'b10_101_00_000, 11'b00_00_10_000_00, 2, 8);
    // Store, dmem_ready high early (ignored in DECODE)
    add(10'b11_010_00_000, 11'b11_00_01_000_00, 3, 12);
    add(10'b11_010_00_000, 11'b00_00_01_000_00, 3, 12);
    add(10'b11_010_00_000, 11'b00_11_01_000_00, 3, 12);
    add(10'b11_010_00_000, 11'b00_00_00_000_00, 3, 12);
    // JAL
    add(10'b10_001_00_001, 11'b11_00_01_000_00, 4, 16);
    add(10'b10_001_00_001, 11'b00_00_01_000_00, 4, 16);
    add(10'b10_001_00_001, 11'b00_00_10_001_00, 4, 16);
    // Halt, then readies ignored while halted
    add(10'b11_000_10_000, 11'b11_00_01_000_00, 5, 'h50);
    add(10'b11_000_10_000, 11'b00_00_01_000_00, 5, 'h50);
    add(10'b11_000_10_000, 11'b00_00_01_000_10, 5, 'h50);
    add(10'b11_000_10_000, 11'b00_00_01_000_10, 5, 'h50);

    do_reset();
    for (int i = 0; i < vecs.size(); i++) begin
      {imem_ready, dmem_ready, dec_load, dec_store, dec_rd_we, dec_halt, dec_illegal,
       dec_branch_type} = vecs[i].in;
      exp_q.push_back(vecs[i]);
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("v%0d imem_req", i),    32'(imem_req),    32'(e.out[10]));
      chk($sformatf("v%0d ir_we", i),       32'(ir_we),       32'(e.out[9]));
      chk($sformatf("v%0d dmem_req", i),    32'(dmem_req),    32'(e.out[8]));
      chk($sformatf("v%0d dmem_we", i),     32'(dmem_we),     32'(e.out[7]));
      chk($sformatf("v%0d reg_we", i),      32'(reg_we),      32'(e.out[6]));
      chk($sformatf("v%0d stay", i),        32'(stay),        32'(e.out[5]));
      chk($sformatf("v%0d branch_type", i), 32'(branch_type), 32'(e.out[4:2]));
      chk($sformatf("v%0d halted", i),      32'(halted),      32'(e.out[1]));
      chk($sformatf("v%0d trap", i),        32'(trap),        32'(e.out[0]));
      chk($sformatf("v%0d retired", i),     retired,          e.ret);
      chk($sformatf("v%0d pc", i),          pc,               e.pc);
      step();
    end

    // Fetch timeout with TIMEOUT=4: four wait cycles then TRAP
    do_reset();
    dec_rd_we = 1'b1;
    step();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk($sformatf("to fetch%0d imem_req", k), 32'(t4_imem_req), 32'd1);
      chk($sformatf("to fetch%0d trap", k), 32'(t4_trap), 32'd0);
      step();
    end
    @(negedge clk);
    chk("to trap", 32'(t4_trap), 32'd1);
    chk("to imem_req", 32'(t4_imem_req), 32'd0);
    chk("to stay", 32'(t4_stay), 32'd1);
    imem_ready = 1'b1;
    step();
    @(negedge clk);
    chk("to sticky trap", 32'(t4_trap), 32'd1);
    chk("to ready ignored ir_we", 32'(t4_ir_we), 32'd0);

    // Ready in the 4th wait cycle wins over the timeout
    do_reset();
    dec_rd_we = 1'b1;
    step();
    for (int k = 1; k <= 3; k++) step();
    imem_ready = 1'b1;
    @(negedge clk);
    chk("late ir_we", 32'(t4_ir_we), 32'd1);
    step();
    @(negedge clk);
    chk("late decode imem_req", 32'(t4_imem_req), 32'd0);
    chk("late decode trap", 32'(t4_trap), 32'd0);
    step();
    @(negedge clk);
    chk("late wb stay", 32'(t4_stay), 32'd0);
    chk("late wb reg_we", 32'(t4_reg_we), 32'd1);
    step();
    @(negedge clk);
    chk("late retired", t4_retired, 32'd1);

    // Illegal together with halt traps; halt alone halts
    do_reset();
    imem_ready = 1'b1; dec_illegal = 1'b1; dec_halt = 1'b1;
    step(); step(); step();
    @(negedge clk);
    chk("ill trap", 32'(trap), 32'd1);
    chk("ill halted", 32'(halted), 32'd0);
    chk("ill retired", retired, 32'd0);
    chk("ill imem_req", 32'(imem_req), 32'd0);
    do_reset();
    imem_ready = 1'b1; dec_halt = 1'b1;
    step(); step(); step();
    @(negedge clk);
    chk("hlt halted", 32'(halted), 32'd1);
    chk("hlt trap", 32'(trap), 32'd0);
    chk("hlt stay", 32'(stay), 32'd1);

    // Asynchronous reset in the middle of a data access
    do_reset();
    imem_ready = 1'b1; dec_rd_we = 1'b1;
    step(); step(); step(); step();
    dec_load = 1'b1; dmem_ready = 1'b0;
    step(); step();
    @(negedge clk);
    chk("ar mem dmem_req", 32'(dmem_req), 32'd1);
    chk("ar mem retired", retired, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("ar dmem_req", 32'(dmem_req), 32'd0);
    chk("ar stay", 32'(stay), 32'd1);
    chk("ar retired", retired, 32'd0);
    @(posedge clk);
    #3 rstn = 1'b1;
    @(negedge clk);
    chk("ar boot imem_req", 32'(imem_req), 32'd0);
    step();
    @(negedge clk);
    chk("ar fetch imem_req", 32'(imem_req), 32'd1);
    chk("ar fetch pc", pc, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Multi-cycle control FSM that sequences the program-counter unit, instruction memory and data memory for one instruction at a time. It drives the PC unit's stay input so that the PC advances exactly once per retired instruction. It gates branch_type to the PC unit and issues req/ready handshakes to both memories. It also provides halt/trap status and a retired-instruction counter.

Parameters:
TIMEOUT, 255, maximum cycles to wait for a memory ready before trapping (1..2^CNT_W-1)
CNT_W, 8, width of the internal wait counter

Ports:
clk  input  1  core clock
rstn  input  1  reset; asynchronous, active-low
imem_ready  input  1  instruction memory has data; accepted in the cycle where imem_req&&imem_ready
dmem_ready  input  1  data memory completed access; accepted in the cycle where dmem_req&&dmem_ready
dec_load  input  1  decoded instruction is a load
dec_store  input  1  decoded instruction is a store
dec_rd_we  input  1  decoded instruction writes rd (ALU, load, JAL, JALR, LUI, AUIPC)
dec_halt  input  1  decoded instruction is EBREAK/ECALL
dec_illegal  input  1  decoder flagged an illegal opcode
dec_branch_type  input  3  branch type from the decoder (JMP_* encoding, 0 = none)
imem_req  output  1  instruction fetch request
ir_we  output  1  load the instruction register
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write (valid only with dmem_req)
reg_we  output  1  register file write enable
stay  output  1  to the PC unit: hold the PC
branch_type  output  3  to the PC unit: dec_branch_type in WB, else 0
halted  output  1  sticky; set on halt
trap  output  1  sticky; set on illegal instruction or timeout
retired  output  32  count of retired instructions

Behaviour:
- Reset (rstn low, asynchronous): state=BOOT, wait counter=0, retired=0, halted=0, trap=0. All outputs are 0 except stay=1. Any in-flight request is dropped immediately, and memories must tolerate this.
- States: BOOT, FETCH, DECODE, MEM, WB, HALT, TRAP. State is encoded in the shared package enum.
- BOOT: held for exactly one cycle after reset deassertion, then FETCH.
- FETCH:
  - imem_req=1, held until accepted.
  - On imem_ready: ir_we=1 in that same cycle, then DECODE.
- DECODE:
  - Priority: dec_illegal -> TRAP; else dec_halt -> HALT; else dec_load|dec_store -> MEM; else -> WB.
- MEM:
  - dmem_req=1 and dmem_we=dec_store, both held until accepted.
  - On dmem_ready -> WB.
- WB (exactly one cycle):
  - stay=0, branch_type=dec_branch_type, reg_we=dec_rd_we, retired+=1 (wraps 2^32-1 -> 0).
  - Next state is FETCH, so the PC updates at the WB->FETCH edge.
- stay=1 in every state other than WB.
- Minimum latency per instruction: ALU/branch 3 cycles (FETCH, DECODE, WB) with zero-wait memory; load/store 4 cycles.
- Timeout:
  - The wait counter clears on entry to FETCH or MEM and increments each cycle ready is low.
  - If the counter reaches TIMEOUT with ready low -> TRAP.
  - If ready arrives in the same cycle the counter reaches TIMEOUT, ready wins and the access completes normally.
- HALT/TRAP:
  - Terminal until reset. halted or trap is set on entry.
  - All requests are 0, stay=1, and retired is frozen.
  - An illegal instruction presented together with halt goes to TRAP, with halted=0.
- Decoder inputs are sampled only in DECODE, MEM and WB. They must stay stable from DECODE through WB.
- dmem_ready or imem_ready arriving outside the corresponding request state is ignored.
- Outputs are decoded combinationally from the registered state plus the listed inputs. No output depends combinationally on a ready signal, except ir_we (FETCH && imem_ready).

Decomposition:
- Shared package:
  - State enum seq_state_t.
  - The JMP_* branch-type constants already used by the PC unit (JMP_NONE=0).
  - Default TIMEOUT value.
- Sub-module mem_wait_timer (clear, count, TIMEOUT compare, expired flag). It is instantiated once and shared between FETCH and MEM, since only one wait is active at a time.

Test Plan:
- ALU instruction (dec_rd_we=1, branch 0) with imem_ready tied high -> stay low for only 1 of every 3 cycles, PC 0->4->8, reg_we pulses in WB, retired=2 after two instructions.
- Load with dmem_ready delayed 5 cycles -> dmem_req high for 6 cycles with dmem_we=0, WB follows the ready cycle, instruction takes 9 cycles total.
- JAL (dec_branch_type=JMP_JAL) -> branch_type nonzero only in the WB cycle, PC takes the offset target, reg_we=1.
- imem_ready never asserted with TIMEOUT=4 -> TRAP after 4 wait cycles, trap=1, imem_req=0, stay=1. With imem_ready on the 4th cycle instead -> normal DECODE.
- dec_illegal=1 together with dec_halt=1 -> TRAP, halted=0, retired unchanged. With dec_halt=1 alone -> HALT, halted=1.
- rstn pulled low mid-MEM (asynchronous, between edges) -> dmem_req drops immediately, retired=0. After release: one BOOT cycle, then imem_req=1 with PC=0.
